spike_window_arbiter: RTL

SPIKE_WINDOW_ARBITER -- requirements
Module: spike_window_arbiter

---
 rtl/spike_window_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spike_window_arbiter.sv
// Round-robin owner of a shared spike_generator bank: one fixed-length window per grant, one-cycle gap between windows.
// Optional build macro SPIKE_WINDOW_OVERRUN_CNT_EN adds o_overrun_cnt (requests that hit an already-pending bit).
module spike_window_arbiter #(
    parameter int P_DELAY    = 5,
    parameter int P_EN_START = 3
) (
    input  logic       i_clk,
    input  logic       w_reset_n,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant,
    output logic [1:0] o_grant_id,
    output logic       o_window_en,
    output logic       o_busy,
`ifdef SPIKE_WINDOW_OVERRUN_CNT_EN
    output logic [7:0] o_overrun_cnt,
`endif
    output logic [3:0] o_pending
);

    localparam int CW = $clog2(P_DELAY) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(P_DELAY);
    localparam logic [CW-1:0] CNT_EN  = CW'(P_EN_START);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic          window_en_q, window_en_d;
    logic [3:0]    grant_clear;
    logic          win_vld;
    logic [1:0]    win_id;
    logic [1:0]    rr_idx;

    // Walk offsets from farthest to nearest so the nearest pending bit after the last owner is the final write.
    always_comb begin
        win_vld = 1'b0;
        win_id  = grant_id_q;
        rr_idx  = grant_id_q;
        for (int i = 4; i >= 1; i--) begin
            rr_idx = grant_id_q + 2'(i);
            if (pending_q[rr_idx]) begin
                win_vld = 1'b1;
                win_id  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_clear = 4'b0000;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_vld) begin
                    state_d     = ST_RUN;
                    cnt_d       = CNT_ONE;
                    grant_d     = 4'b0001 << win_id;
                    grant_id_d  = win_id;
                    grant_clear = 4'b0001 << win_id;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    grant_d = 4'b0000;
                end
            end
            ST_RUN: begin
                if (cnt_q >= CNT_MAX) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    grant_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = 4'b0000;
            end
        endcase
        // A fresh strobe on the bit being granted re-arms it, so that requester gets another window later.
        pending_d   = (pending_q & ~grant_clear) | i_req;
        window_en_d = (state_d == ST_RUN) && (cnt_d >= CNT_EN);
    end

    always_ff @(posedge i_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pending_q   <= 4'b0000;
            grant_q     <= 4'b0000;
            grant_id_q  <= 2'd3;
            window_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            window_en_q <= window_en_d;
        end
    end

`ifdef SPIKE_WINDOW_OVERRUN_CNT_EN
    logic [7:0] overrun_q, overrun_d;
    logic [3:0] overrun_hits;
    logic [8:0] overrun_sum;

    always_comb begin
        overrun_hits = i_req & pending_q & ~grant_clear;
        overrun_sum  = {1'b0, overrun_q}
                     + 9'(overrun_hits[0]) + 9'(overrun_hits[1])
                     + 9'(overrun_hits[2]) + 9'(overrun_hits[3]);
        overrun_d    = overrun_sum[8] ? 8'hFF : overrun_sum[7:0];
    end

    always_ff @(posedge i_clk or negedge w_reset_n) begin
        if (!w_reset_n) overrun_q <= 8'd0;
        else            overrun_q <= overrun_d;
    end

    assign o_overrun_cnt = overrun_q;
`endif

    assign o_grant     = grant_q;
    assign o_grant_id  = grant_id_q;
    assign o_window_en = window_en_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_pending   = pending_q;

endmodule
